// File: rtl/axist_rx_to_avst_rx_adapter.sv
// Receive-side adapter: MAC AXI-ST RX beats become Avalon-ST RX client beats one cycle later,
// with regenerated SOP, empty, frame length, framing-error flag, ingress timestamp and statistics.
module axist_rx_to_avst_rx_adapter #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned NO_OF_BYTES   = 8,
  parameter int unsigned EMPTY_BITS    = 3,
  parameter int unsigned MAX_FRAME_LEN = 1518
) (
  input  logic                   i_rx_clk,
  input  logic                   i_rx_rst,
  input  logic                   i_axi_st_rx_tvalid,
  input  logic [DATA_WIDTH-1:0]  i_axi_st_rx_tdata,
  input  logic                   i_axi_st_rx_tlast,
  input  logic [NO_OF_BYTES-1:0] i_axi_st_rx_tkeep,
  input  logic [4:0]             i_axi_st_rx_tuser_sts,
  input  logic [31:0]            i_axi_st_rx_tuser_sts_extended,
  input  logic [95:0]            i_axi_st_rx_ingrts0_tdata,
  input  logic                   i_axi_st_rx_ingrts0_tvalid,
  input  logic                   i_clr_stats,
  output logic                   o_av_st_rx_valid,
  output logic [DATA_WIDTH-1:0]  o_av_st_rx_data,
  output logic                   o_av_st_rx_startofpacket,
  output logic                   o_av_st_rx_endofpacket,
  output logic [EMPTY_BITS-1:0]  o_av_st_rx_empty,
  output logic [5:0]             o_av_st_rx_error,
  output logic                   o_av_st_rxstatus_valid,
  output logic [39:0]            o_av_st_rxstatus_data,
  output logic [95:0]            o_av_st_ptp_rx_its,
  output logic                   o_av_st_ptp_rx_its_valid,
  output logic [15:0]            o_rx_pkt_len,
  output logic [31:0]            o_rx_pkt_cnt,
  output logic [31:0]            o_rx_err_cnt
);

  localparam int unsigned CntW = $clog2(NO_OF_BYTES + 1);

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  state_e state_q, state_d;

  // Per-frame tracking
  logic [15:0]           len_q;
  logic                  ferr_q;
  logic                  cap_vld_q, cap_vld_d;
  logic [95:0]           cap_ts_q, cap_ts_d;

  // Registered outputs
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic [EMPTY_BITS-1:0] empty_q, empty_d;
  logic [5:0]            err_q, err_d;
  logic                  rxs_valid_q, rxs_valid_d;
  logic [39:0]           rxs_data_q, rxs_data_d;
  logic [95:0]           its_q, its_d;
  logic                  its_valid_q, its_valid_d;
  logic [15:0]           pkt_len_q, pkt_len_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic [31:0]           err_cnt_q, err_cnt_d;

  logic                   sop, eop, keep_contig, frame_ferr, oversize, ts_take;
  logic [CntW-1:0]        keep_cnt;
  logic [NO_OF_BYTES-1:0] keep_inc;
  logic [16:0]            len_sum;
  logic [15:0]            len_new;
  logic [5:0]             err_vec;

  function automatic logic [CntW-1:0] popcount(input logic [NO_OF_BYTES-1:0] v);
    logic [CntW-1:0] c;
    c = '0;
    for (int i = 0; i < NO_OF_BYTES; i++) c = c + CntW'(v[i]);
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_axi_st_rx_tvalid && !i_axi_st_rx_tlast) state_d = StInPkt;
      StInPkt: if (i_axi_st_rx_tvalid && i_axi_st_rx_tlast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sop      = i_axi_st_rx_tvalid && (state_q == StIdle);
    eop      = i_axi_st_rx_tvalid && i_axi_st_rx_tlast;
    keep_cnt = popcount(i_axi_st_rx_tkeep);
    // Contiguous-from-bit-0 masks have no set bit above the carry out of +1; zero is illegal too
    keep_inc    = i_axi_st_rx_tkeep + NO_OF_BYTES'(1);
    keep_contig = ((i_axi_st_rx_tkeep & keep_inc) == '0) && (i_axi_st_rx_tkeep != '0);
    len_sum     = {1'b0, (sop ? 16'd0 : len_q)} + 17'(keep_cnt);
    len_new     = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    frame_ferr  = (!sop && ferr_q) || !keep_contig ||
                  (!i_axi_st_rx_tlast && (i_axi_st_rx_tkeep != {NO_OF_BYTES{1'b1}}));
    oversize    = 32'(len_new) > MAX_FRAME_LEN;
    err_vec     = {frame_ferr || oversize, i_axi_st_rx_tuser_sts};
    // Only the first pulse between the SOP and EOP input cycles counts
    ts_take   = i_axi_st_rx_ingrts0_tvalid && (sop || (state_q == StInPkt && !cap_vld_q));
    cap_vld_d = ts_take || (!sop && cap_vld_q);
    cap_ts_d  = ts_take ? i_axi_st_rx_ingrts0_tdata : (sop ? '0 : cap_ts_q);
  end

  always_comb begin
    valid_d     = 1'b0;
    data_d      = data_q;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    empty_d     = '0;
    err_d       = '0;
    rxs_valid_d = 1'b0;
    rxs_data_d  = '0;
    its_d       = '0;
    its_valid_d = 1'b0;
    pkt_len_d   = '0;
    if (i_axi_st_rx_tvalid) begin
      valid_d = 1'b1;
      data_d  = i_axi_st_rx_tdata;
      sop_d   = sop;
      if (i_axi_st_rx_tlast) begin
        eop_d       = 1'b1;
        empty_d     = EMPTY_BITS'(NO_OF_BYTES - 32'(keep_cnt));
        err_d       = err_vec;
        rxs_valid_d = 1'b1;
        rxs_data_d  = {3'd0, i_axi_st_rx_tuser_sts_extended, i_axi_st_rx_tuser_sts};
        its_valid_d = cap_vld_d;
        its_d       = cap_vld_d ? cap_ts_d : '0;
        pkt_len_d   = len_new;
      end
    end
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (i_clr_stats) begin
      pkt_cnt_d = '0;
      err_cnt_d = '0;
    end else if (eop) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (err_vec != '0) err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_rx_clk) begin
    if (i_rx_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_rx_clk) begin
    if (i_rx_rst) begin
      len_q       <= '0;
      ferr_q      <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_ts_q    <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      empty_q     <= '0;
      err_q       <= '0;
      rxs_valid_q <= 1'b0;
      rxs_data_q  <= '0;
      its_q       <= '0;
      its_valid_q <= 1'b0;
      pkt_len_q   <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (i_axi_st_rx_tvalid) begin
        len_q  <= len_new;
        ferr_q <= frame_ferr;
      end
      cap_vld_q   <= cap_vld_d;
      cap_ts_q    <= cap_ts_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      empty_q     <= empty_d;
      err_q       <= err_d;
      rxs_valid_q <= rxs_valid_d;
      rxs_data_q  <= rxs_data_d;
      its_q       <= its_d;
      its_valid_q <= its_valid_d;
      pkt_len_q   <= pkt_len_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_av_st_rx_valid         = valid_q;
  assign o_av_st_rx_data          = data_q;
  assign o_av_st_rx_startofpacket = sop_q;
  assign o_av_st_rx_endofpacket   = eop_q;
  assign o_av_st_rx_empty         = empty_q;
  assign o_av_st_rx_error         = err_q;
  assign o_av_st_rxstatus_valid   = rxs_valid_q;
  assign o_av_st_rxstatus_data    = rxs_data_q;
  assign o_av_st_ptp_rx_its       = its_q;
  assign o_av_st_ptp_rx_its_valid = its_valid_q;
  assign o_rx_pkt_len             = pkt_len_q;
  assign o_rx_pkt_cnt             = pkt_cnt_q;
  assign o_rx_err_cnt             = err_cnt_q;

endmodule

// File: tb/tb_axist_rx_to_avst_rx_adapter.sv
// Scoreboard bench: each frame's expected output beats are derived from frame-level rules and
// queued at drive time; a negedge monitor pops and compares whenever the adapter emits a beat.
module tb_axist_rx_to_avst_rx_adapter;
  localparam int MAXL = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid, tlast, ts_v, clr;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [4:0]  sts;
  logic [31:0] ext;
  logic [95:0] ts;

  logic        o_valid, o_sop, o_eop, o_rxsv, o_its_v;
  logic [63:0] o_data;
  logic [2:0]  o_empty;
  logic [5:0]  o_err;
  logic [39:0] o_rxs;
  logic [95:0] o_its;
  logic [15:0] o_len;
  logic [31:0] o_pkt, o_errc;

  always #5 clk = ~clk;

  axist_rx_to_avst_rx_adapter #(
    .DATA_WIDTH(64), .NO_OF_BYTES(8), .EMPTY_BITS(3), .MAX_FRAME_LEN(MAXL)
  ) dut (
    .i_rx_clk(clk), .i_rx_rst(rst),
    .i_axi_st_rx_tvalid(tvalid), .i_axi_st_rx_tdata(tdata), .i_axi_st_rx_tlast(tlast),
    .i_axi_st_rx_tkeep(tkeep), .i_axi_st_rx_tuser_sts(sts),
    .i_axi_st_rx_tuser_sts_extended(ext), .i_axi_st_rx_ingrts0_tdata(ts),
    .i_axi_st_rx_ingrts0_tvalid(ts_v), .i_clr_stats(clr),
    .o_av_st_rx_valid(o_valid), .o_av_st_rx_data(o_data),
    .o_av_st_rx_startofpacket(o_sop), .o_av_st_rx_endofpacket(o_eop),
    .o_av_st_rx_empty(o_empty), .o_av_st_rx_error(o_err),
    .o_av_st_rxstatus_valid(o_rxsv), .o_av_st_rxstatus_data(o_rxs),
    .o_av_st_ptp_rx_its(o_its), .o_av_st_ptp_rx_its_valid(o_its_v),
    .o_rx_pkt_len(o_len), .o_rx_pkt_cnt(o_pkt), .o_rx_err_cnt(o_errc)
  );

  typedef struct {
    logic [63:0] data;
    logic        sop, eop, its_v;
    logic [2:0]  empty;
    logic [15:0] len;
    logic [5:0]  err;
    logic [39:0] rxs;
    logic [95:0] its;
    logic [31:0] pkt, errc;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0, n_bad = 0;
  logic [31:0] m_pkt = 0, m_err = 0;
  bit          mon_en = 0;
  logic [7:0]  kq[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mask_of(input int k);
    logic [8:0] t;
    t = (9'd1 << k) - 9'd1;
    return t[7:0];
  endfunction

  function automatic bit legal(input logic [7:0] k);
    return (k != 8'h00) && (k == mask_of($countones(k)));
  endfunction

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 96'(o_valid), 96'(0));
        end else begin
          e = q.pop_front();
          chk("data", 96'(o_data), 96'(e.data));
          chk("sop", 96'(o_sop), 96'(e.sop));
          chk("eop", 96'(o_eop), 96'(e.eop));
          chk("empty", 96'(o_empty), 96'(e.empty));
          chk("error", 96'(o_err), 96'(e.err));
          chk("rxstatus_valid", 96'(o_rxsv), 96'(e.eop));
          chk("rxstatus_data", 96'(o_rxs), 96'(e.rxs));
          chk("its", o_its, e.its);
          chk("its_valid", 96'(o_its_v), 96'(e.its_v));
          chk("pkt_len", 96'(o_len), 96'(e.len));
          chk("pkt_cnt", 96'(o_pkt), 96'(e.pkt));
          chk("err_cnt", 96'(o_errc), 96'(e.errc));
        end
      end else begin
        chk("idle_flags", 96'({o_sop, o_eop, o_rxsv, o_err}), 96'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    ts_v   = 1'b0;
    clr    = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic idle(input bit p, input logic [95:0] t, input bit c);
    tvalid = 1'b0;
    ts_v   = p;
    ts     = t;
    clr    = c;
    if (c) begin
      m_pkt = 0;
      m_err = 0;
    end
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 96'(o_valid), 96'(0));
    chk({tag, "_data"}, 96'(o_data), 96'(0));
    chk({tag, "_flags"}, 96'({o_sop, o_eop, o_rxsv, o_its_v}), 96'(0));
    chk({tag, "_err_empty_len"}, 96'({o_err, o_empty, o_len}), 96'(0));
    chk({tag, "_its_rxs"}, o_its | 96'(o_rxs), 96'(0));
    chk({tag, "_counters"}, 96'({o_pkt, o_errc}), 96'(0));
  endtask

  // abort_at >= 0 drives that beat together with reset and abandons the frame.
  task automatic send_frame(input logic [7:0] keeps[$], input logic [4:0] s, input logic [31:0] x,
                            input logic [15:0] ts_mask, input bit gaps, input bit clr_eop,
                            input int abort_at);
    int          n, total;
    bit          ferr, have_ts, last, p;
    logic [95:0] ts_val, t;
    exp_t        e;
    n = keeps.size();
    total = 0;
    ferr = 0;
    have_ts = 0;
    ts_val = '0;
    foreach (keeps[i]) begin
      total += $countones(keeps[i]);
      if (!legal(keeps[i]) || (i != n - 1 && keeps[i] != 8'hFF)) ferr = 1;
    end
    if (total > MAXL) ferr = 1;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        while ($urandom_range(0, 2) == 0) begin
          p = ($urandom_range(0, 3) == 0);
          t = rand96();
          if (p && !have_ts) begin
            have_ts = 1;
            ts_val = t;
          end
          idle(p, t, 1'b0);
        end
      end
      last   = (i == n - 1);
      p      = ts_mask[i];
      t      = rand96();
      tvalid = 1'b1;
      tdata  = {$urandom, $urandom};
      tkeep  = keeps[i];
      tlast  = last;
      sts    = last ? s : 5'($urandom);
      ext    = last ? x : $urandom;
      ts_v   = p;
      ts     = t;
      if (i == abort_at) begin
        rst   = 1'b1;
        m_pkt = 0;
        m_err = 0;
        tick();
        return;
      end
      clr = last && clr_eop;
      if (p && !have_ts) begin
        have_ts = 1;
        ts_val = t;
      end
      e.data  = tdata;
      e.sop   = (i == 0);
      e.eop   = last;
      e.empty = last ? 3'(8 - $countones(keeps[i])) : 3'd0;
      e.len   = last ? ((total > 65535) ? 16'hFFFF : 16'(total)) : 16'd0;
      e.err   = last ? {ferr, s} : 6'd0;
      e.rxs   = last ? {3'd0, x, s} : 40'd0;
      e.its_v = last && have_ts;
      e.its   = e.its_v ? ts_val : 96'd0;
      if (clr) begin
        m_pkt = 0;
        m_err = 0;
      end else if (last) begin
        m_pkt++;
        if (e.err != 0) m_err++;
      end
      e.pkt  = m_pkt;
      e.errc = m_err;
      q.push_back(e);
      tick();
    end
  endtask

  task automatic fill(input int nb, input logic [7:0] last_keep);
    kq.delete();
    for (int b = 0; b < nb; b++) kq.push_back(8'hFF);
    kq[nb-1] = last_keep;
  endtask

  initial begin
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; ts_v = 1'b0; clr = 1'b0;
    tdata = '0; tkeep = '0; sts = '0; ext = '0; ts = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    mon_en = 1;
    @(posedge clk);
    #1;

    fill(8, 8'hFF);             send_frame(kq, 5'h00, 32'h1234_5678, 16'h0, 0, 0, -1);
    fill(8, 8'h1F);             send_frame(kq, 5'h02, 32'hCAFE_F00D, 16'h0, 0, 0, -1);
    fill(1, 8'h0F);             send_frame(kq, 5'h00, 32'h0, 16'h0, 0, 0, -1);
    fill(1, 8'h0F);             send_frame(kq, 5'h00, 32'h0, 16'h0, 0, 0, -1);
    fill(8, 8'hFF); kq[2] = 8'hF5;
    send_frame(kq, 5'h00, 32'h0, 16'h0, 0, 0, -1);
    fill(4, 8'h0F); kq[1] = 8'h00;
    send_frame(kq, 5'h00, 32'h0, 16'h0, 0, 0, -1);
    fill(3, 8'hFF); kq[1] = 8'h0F;
    send_frame(kq, 5'h00, 32'h0, 16'h0, 0, 0, -1);
    fill(9, 8'hFF);             send_frame(kq, 5'h00, 32'h0, 16'h0, 0, 0, -1);
    idle(1'b1, rand96(), 1'b0);
    fill(8, 8'hFF);             send_frame(kq, 5'h00, 32'h0, 16'h0014, 0, 0, -1);
    fill(8200, 8'hFF);          send_frame(kq, 5'h00, 32'h0, 16'h0, 0, 0, -1);

    fill(8, 8'hFF);             send_frame(kq, 5'h00, 32'h0, 16'h0, 0, 0, 3);
    @(negedge clk);
    check_zero("reset_mid");
    rst = 1'b1;
    tick();
    fill(4, 8'hFF);             send_frame(kq, 5'h00, 32'h0, 16'h0, 0, 0, -1);
    fill(3, 8'h07);             send_frame(kq, 5'h00, 32'h0, 16'h0, 0, 1, -1);

    for (int f = 0; f < 250; f++) begin
      int nb;
      nb = $urandom_range(1, 12);
      fill(nb, mask_of($urandom_range(1, 8)));
      if ($urandom_range(0, 5) == 0) kq[$urandom_range(0, nb - 1)] = 8'($urandom_range(1, 255));
      send_frame(kq, ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0, $urandom,
                 16'($urandom) & 16'($urandom), 1, ($urandom_range(0, 19) == 0), -1);
      repeat ($urandom_range(0, 3)) idle(($urandom_range(0, 2) == 0), rand96(),
                                         ($urandom_range(0, 29) == 0));
    end

    repeat (5) idle(1'b0, '0, 1'b0);
    chk("queue_drained", 96'(q.size()), 96'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axist_rx_to_avst_rx_adapter.md
Name: axist_rx_to_avst_rx_adapter

Overview:
- Single-clock receive-side adapter. Converts the MAC's AXI-ST RX stream (tlast/tkeep/tuser) into the Avalon-ST RX client stream (sop/eop/empty/error/rxstatus) used by the user/HPS side.
- Regenerates SOP, converts tkeep to empty, and accumulates frame length per packet.
- Flags framing violations and attaches the ingress PTP timestamp to the EOP beat.
- Maintains packet and error statistics counters. The MAC RX path has no backpressure, so the block has no ready.

Parameters:
- DATA_WIDTH, 64, data bus width in bits.
- NO_OF_BYTES, 8, bytes per beat (DATA_WIDTH/8).
- EMPTY_BITS, 3, width of empty (clog2(NO_OF_BYTES)).
- MAX_FRAME_LEN, 1518, largest legal frame in bytes; larger frames are flagged oversize.

Ports:
- i_rx_clk  in  1  sole clock.
- i_rx_rst  in  1  synchronous, active-high reset.
- i_axi_st_rx_tvalid  in  1  beat valid.
- i_axi_st_rx_tdata  in  DATA_WIDTH  beat data; byte 0 = bits[7:0].
- i_axi_st_rx_tlast  in  1  last beat of frame.
- i_axi_st_rx_tkeep  in  NO_OF_BYTES  byte enables; legal form is contiguous ones from bit 0.
- i_axi_st_rx_tuser_sts  in  5  MAC status/error, sampled on the tlast beat.
- i_axi_st_rx_tuser_sts_extended  in  32  extended status, sampled on the tlast beat.
- i_axi_st_rx_ingrts0_tdata  in  96  ingress timestamp.
- i_axi_st_rx_ingrts0_tvalid  in  1  timestamp valid (single-cycle).
- i_clr_stats  in  1  pulse; clears the statistics counters.
- o_av_st_rx_valid  out  1  output beat valid.
- o_av_st_rx_data  out  DATA_WIDTH  output data.
- o_av_st_rx_startofpacket  out  1  first beat of frame.
- o_av_st_rx_endofpacket  out  1  last beat of frame.
- o_av_st_rx_empty  out  EMPTY_BITS  unused bytes on the EOP beat.
- o_av_st_rx_error  out  6  [4:0] = MAC sts; [5] = adapter framing error. Valid on EOP only.
- o_av_st_rxstatus_valid  out  1  high on the EOP beat.
- o_av_st_rxstatus_data  out  40  {3'd0, sts_extended[31:0], sts[4:0]}.
- o_av_st_ptp_rx_its  out  96  captured timestamp. Valid on EOP when its_valid is set.
- o_av_st_ptp_rx_its_valid  out  1  timestamp was captured for this frame.
- o_rx_pkt_len  out  16  frame byte length, presented on the EOP beat.
- o_rx_pkt_cnt  out  32  frames delivered.
- o_rx_err_cnt  out  32  frames with any error bit set.

Behaviour:
- **Reset.** Every output is 0 and the FSM returns to IDLE. Reset mid-packet discards the partial frame. The next valid beat after reset is marked SOP.
- **Latency.** Fixed 1 cycle. An input beat accepted at cycle N appears at cycle N+1 with o_av_st_rx_valid=1.
- **Idle cycles.** When tvalid=0, the next cycle has valid, sop, eop, rxstatus_valid and error all 0; data holds its previous value.
- **FSM states.** IDLE and IN_PKT.
  - IDLE with tvalid: sop=1. If tlast, stay in IDLE (single-beat frame: sop and eop in the same cycle); otherwise go to IN_PKT.
  - IN_PKT with tvalid: sop=0. If tlast, go to IDLE.
  - tvalid=0 never changes state.
- **Empty.** empty = NO_OF_BYTES − popcount(tkeep) on the EOP beat, and 0 on non-EOP beats. A full beat (tkeep all ones) gives 0.
- **Length.** A 16-bit accumulator resets at SOP and adds popcount(tkeep) on each beat. It saturates at 0xFFFF. o_rx_pkt_len equals the final sum on EOP and is 0 otherwise.
- **Framing error (error[5]).** Sticky per frame; set if any of the following occur, cleared at the next SOP:
  - tkeep is non-contiguous;
  - tkeep is 0 on a valid beat;
  - tkeep is not all ones on a non-last beat;
  - final length > MAX_FRAME_LEN.
- **Timestamp.** The first ingrts0_tvalid seen from the SOP input cycle through the EOP input cycle, inclusive, is captured. Later pulses in the same frame are ignored, as are pulses seen in IDLE without a concurrent tvalid beat. If nothing was captured, EOP shows its_valid=0 and its=0.
- **Statistics counters.**
  - pkt_cnt increments on each output EOP; err_cnt increments on each output EOP with error≠0. Both wrap at 2^32.
  - i_clr_stats takes priority: if it coincides with an increment, the result is 0.

Test Plan:
- 64-byte frame, 8 beats of tkeep=0xFF, tlast on beat 8 -> one cycle later: sop on beat 1, eop on beat 8, empty=0, len=64, error=0, pkt_cnt=1.
- 61-byte frame, last tkeep=0x1F, sts=5'h02 on the tlast beat -> empty=3, len=61, error=6'h02, rxstatus_data[4:0]=5'h02, err_cnt=1.
- Single beat, tkeep=0x0F, tlast=1 -> sop=eop=1 in the same cycle, empty=4, len=4; a following beat is sop again.
- Framing violations -> error[5]=1 and err_cnt increments:
  - mid-frame tkeep=0xF5;
  - MAX_FRAME_LEN=64 with 9 full beats (len=72).
- Timestamp pulses on beats 3 and 5 of an 8-beat frame -> EOP its equals the beat-3 value and its_valid=1. A frame with no pulse -> its_valid=0, its=0.
- i_rx_rst asserted on beat 4 of 8, then 4 more beats sent -> outputs 0 during reset; the first post-reset beat has sop=1. i_clr_stats coinciding with an EOP -> pkt_cnt=0.
